mc_rr_arb: RTL and testbench
============================

MC_RR_ARB -- requirements
Module: mc_rr_arb

Interface
REQ-001 SHALL have parameter N_PORTS, default 2, number of requesters (ICache, LSB, ...), 1..8.
REQ-002 SHALL have parameter MAX_BYTES, default 8, longest transfer in bytes, 1..16.
REQ-003 SHALL have parameter LW, default $clog2(MAX_BYTES+1), width of each length field.
REQ-004 Sys_clk  in  1  sole clock, all state on rising edge.
REQ-005 Sys_rst_n  in  1  reset, asynchronous, active-low.
REQ-006 Sys_rdy  in  1  0 freezes all state and outputs.
REQ-007 io_buffer_full  in  1  UART buffer full (see Configuration).
REQ-008 RAMMC_data  in  8  RAM read byte, valid the cycle after its address is presented.
REQ-009 MCRAM_data / MCRAM_addr / MCRAM_wr  out  8/32/1  RAM write byte, byte address, 1=write; all registered.
REQ-010 req_en / req_wr  in  N_PORTS each  per-port request, held until done; 1=write.
REQ-011 req_len  in  N_PORTS*LW  per-port byte count.
REQ-012 req_addr  in  N_PORTS*32  per-port base address.
REQ-013 req_wdata  in  N_PORTS*8*MAX_BYTES  per-port write data, little-endian.
REQ-014 done  out  N_PORTS  one-cycle completion pulse per port.
REQ-015 rdata  out  N_PORTS*8*MAX_BYTES  per-port read data, little-endian, held until that port's next read completes.

Function
REQ-016 FSM states IDLE, READ, WRITE, FINISH; one transfer in flight at a time.
REQ-017 In IDLE, any req_en=1: grant lowest-index requester at or after rr_ptr, wrapping modulo N_PORTS; latch port, addr, len, wr, wdata.
REQ-018 rr_ptr SHALL become granted index+1 (wrap to 0) at grant; reset value 0.
REQ-019 Effective length = min(req_len, MAX_BYTES); length 0 SHALL go IDLE->FINISH with no RAM access.
REQ-020 READ: addresses base..base+L-1 on MCRAM_addr on consecutive cycles starting cycle after grant, MCRAM_wr=0; byte k captured into rdata[8k+7:8k] one cycle after address k; bytes >=L of rdata SHALL be zeroed.
REQ-021 WRITE: byte k driven on MCRAM_data with MCRAM_addr=base+k, MCRAM_wr=1, on consecutive cycles starting cycle after grant.
REQ-022 FINISH: done[port]=1 for exactly one cycle; MCRAM_addr=0, MCRAM_wr=0; next state IDLE.
REQ-023 Latency: grant cycle G; done at G+L+2 for reads, G+L+1 for writes, G+1 for L=0.
REQ-024 Port just completed SHALL NOT be granted in the cycle after done (one-cycle deassert window).
REQ-025 req_en of granted port dropping mid-transfer SHALL abort: next cycle IDLE, MCRAM_wr=0, MCRAM_addr=0, no done, rdata of that port unchanged.
REQ-026 Address arithmetic SHALL wrap modulo 2^32.
REQ-027 Outside active transfer, MCRAM_addr=0 and MCRAM_wr=0 (writes to 0x0 ignored by RAM).

Reset
REQ-028 Sys_rst_n=0 SHALL immediately force IDLE, rr_ptr=0, done=0, rdata=0, MCRAM_data=0, MCRAM_addr=0, MCRAM_wr=0, including mid-transfer; no done for aborted transfer.

Configuration
REQ-029 Macro MC_IO_STALL_EN: when defined, io_buffer_full=1 freezes FSM, counters and all outputs (same as Sys_rdy=0) for that cycle; when undefined, io_buffer_full SHALL be ignored.

Verification
REQ-030 Port 0 read, addr 0x1000, len 4, RAM bytes 11,22,33,44 -> MCRAM_addr 0x1000..0x1003, done[0] at G+6, rdata[0][31:0]=0x44332211.
REQ-031 Port 1 write, addr 0x2000, len 2, wdata 0xBEEF -> cycles (0x2000,EF,wr=1),(0x2001,BE,wr=1), done[1] at G+3, then wr=0 addr=0.
REQ-032 Ports 0 and 1 request continuously, N_PORTS=2 -> grants alternate 0,1,0,1; neither starves.
REQ-033 Port 0 read len 8 drops req_en after 3 bytes -> IDLE next cycle, no done[0], rdata[0] unchanged.
REQ-034 Sys_rst_n low mid-write of len 4 -> MCRAM_wr=0 immediately, no done; after release, new request served normally.
REQ-035 With MC_IO_STALL_EN, io_buffer_full high 3 cycles mid-write -> MCRAM outputs held, done delayed by exactly 3 cycles; len 0 request -> done at G+1, no RAM access.

Source files
------------

// File: rtl/mc_rr_arb.sv
// mc_rr_arb: round-robin memory-controller arbiter.
// N_PORTS requesters share one byte-wide RAM port. One transfer is in flight
// at a time; reads return little-endian data per port, writes stream bytes out.
// Optional build macro MC_IO_STALL_EN: io_buffer_full=1 freezes the block
// exactly like Sys_rdy=0. Without it, io_buffer_full is ignored.
//
// state  | meaning
// -------+------------------------------------------------------------------
// IDLE   | no transfer; arbitrate among requesters, RAM bus parked at 0
// READ   | issuing read addresses and capturing bytes one cycle later
// WRITE  | driving one write byte per cycle to the RAM
// FINISH | one-cycle done pulse for the granted port, then back to IDLE
module mc_rr_arb #(
  parameter int N_PORTS   = 2,
  parameter int MAX_BYTES = 8,
  parameter int LW        = $clog2(MAX_BYTES + 1)
) (
  input  logic                           Sys_clk,
  input  logic                           Sys_rst_n,
  input  logic                           Sys_rdy,
  input  logic                           io_buffer_full,
  input  logic [7:0]                     RAMMC_data,
  output logic [7:0]                     MCRAM_data,
  output logic [31:0]                    MCRAM_addr,
  output logic                           MCRAM_wr,
  input  logic [N_PORTS-1:0]             req_en,
  input  logic [N_PORTS-1:0]             req_wr,
  input  logic [N_PORTS*LW-1:0]          req_len,
  input  logic [N_PORTS*32-1:0]          req_addr,
  input  logic [N_PORTS*8*MAX_BYTES-1:0] req_wdata,
  output logic [N_PORTS-1:0]             done,
  output logic [N_PORTS*8*MAX_BYTES-1:0] rdata
);

  localparam int DW = 8 * MAX_BYTES;
  localparam int PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    WRITE  = 2'd2,
    FINISH = 2'd3
  } state_t;

  state_t               state;
  logic [PW-1:0]        rr_ptr;
  logic [PW-1:0]        cur_port;
  logic [31:0]          cur_addr;
  logic [LW-1:0]        cur_len;
  logic [DW-1:0]        cur_wdata;
  logic [LW-1:0]        idx;
  logic [DW-1:0]        rbuf;
  logic                 blk_vld;
  logic [PW-1:0]        blk_port;

  logic                 stall;
  logic                 gnt_vld;
  logic [PW-1:0]        gnt_idx;
  logic [N_PORTS-1:0]   gnt_onehot;
  logic [PW-1:0]        rr_next;
  logic [31:0]          sel_addr;
  logic [LW-1:0]        sel_len;
  logic [LW-1:0]        sel_len_eff;
  logic                 sel_wr;
  logic [DW-1:0]        sel_wdata;
  logic                 cur_req;
  logic [N_PORTS-1:0]   cur_onehot;
  logic [LW-1:0]        idx_inc;
  logic [7:0]           wd_byte;
  logic [DW-1:0]        rbuf_next;

`ifdef MC_IO_STALL_EN
  assign stall = !Sys_rdy || io_buffer_full;
`else
  logic unused_io_buffer_full;
  assign unused_io_buffer_full = io_buffer_full;
  assign stall = !Sys_rdy;
`endif

  // Round-robin pick: lowest eligible index at or after rr_ptr, else wrap to
  // the lowest eligible index below it. The port that just finished sits out
  // one IDLE cycle so it cannot be re-granted before it can drop req_en.
  always_comb begin
    gnt_vld    = 1'b0;
    gnt_idx    = '0;
    gnt_onehot = '0;
    for (int p = N_PORTS - 1; p >= 0; p--) begin
      if (req_en[p] && !(blk_vld && blk_port == PW'(p)) && PW'(p) < rr_ptr) begin
        gnt_vld = 1'b1;
        gnt_idx = PW'(p);
      end
    end
    for (int p = N_PORTS - 1; p >= 0; p--) begin
      if (req_en[p] && !(blk_vld && blk_port == PW'(p)) && PW'(p) >= rr_ptr) begin
        gnt_vld = 1'b1;
        gnt_idx = PW'(p);
      end
    end
    for (int p = 0; p < N_PORTS; p++) begin
      gnt_onehot[p] = gnt_vld && (gnt_idx == PW'(p));
    end
  end

  assign rr_next = (gnt_idx == PW'(N_PORTS - 1)) ? '0 : gnt_idx + PW'(1);

  // Mux the granted port's request fields.
  always_comb begin
    sel_addr  = '0;
    sel_len   = '0;
    sel_wr    = 1'b0;
    sel_wdata = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      if (gnt_idx == PW'(p)) begin
        sel_addr  = req_addr[p*32 +: 32];
        sel_len   = req_len[p*LW +: LW];
        sel_wr    = req_wr[p];
        sel_wdata = req_wdata[p*DW +: DW];
      end
    end
  end

  // Oversized requests are clamped to the buffer size.
  assign sel_len_eff = (sel_len > LW'(MAX_BYTES)) ? LW'(MAX_BYTES) : sel_len;

  // Live view of the in-flight port: its request line and one-hot done mask.
  always_comb begin
    cur_req    = 1'b0;
    cur_onehot = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      if (cur_port == PW'(p)) begin
        cur_req       = req_en[p];
        cur_onehot[p] = 1'b1;
      end
    end
  end

  assign idx_inc = idx + LW'(1);

  // Next write byte, selected by the upcoming byte index.
  always_comb begin
    wd_byte = '0;
    for (int b = 0; b < MAX_BYTES; b++) begin
      if (idx_inc == LW'(b)) begin
        wd_byte = cur_wdata[b*8 +: 8];
      end
    end
  end

  // Read capture: in READ with idx=k, the RAM is returning byte k-1.
  always_comb begin
    rbuf_next = rbuf;
    for (int b = 0; b < MAX_BYTES; b++) begin
      if (state == READ && idx == LW'(b + 1)) begin
        rbuf_next[b*8 +: 8] = RAMMC_data;
      end
    end
  end

  // Transfer FSM with registered RAM bus, done pulses and per-port read data.
  always_ff @(posedge Sys_clk or negedge Sys_rst_n) begin
    if (!Sys_rst_n) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      cur_port   <= '0;
      cur_addr   <= '0;
      cur_len    <= '0;
      cur_wdata  <= '0;
      idx        <= '0;
      rbuf       <= '0;
      blk_vld    <= 1'b0;
      blk_port   <= '0;
      MCRAM_data <= '0;
      MCRAM_addr <= '0;
      MCRAM_wr   <= 1'b0;
      done       <= '0;
      rdata      <= '0;
    end else if (!stall) begin
      case (state)
        IDLE: begin
          blk_vld    <= 1'b0;
          done       <= '0;
          MCRAM_addr <= '0;
          MCRAM_wr   <= 1'b0;
          MCRAM_data <= '0;
          if (gnt_vld) begin
            cur_port  <= gnt_idx;
            cur_addr  <= sel_addr;
            cur_len   <= sel_len_eff;
            cur_wdata <= sel_wdata;
            rr_ptr    <= rr_next;
            idx       <= '0;
            rbuf      <= '0;
            if (sel_len_eff == '0) begin
              // Empty transfer: no RAM cycle; an empty read still completes
              // and leaves that port's read data all zero.
              state <= FINISH;
              done  <= gnt_onehot;
              for (int p = 0; p < N_PORTS; p++) begin
                if (gnt_onehot[p] && !sel_wr) begin
                  rdata[p*DW +: DW] <= '0;
                end
              end
            end else if (sel_wr) begin
              state      <= WRITE;
              MCRAM_addr <= sel_addr;
              MCRAM_data <= sel_wdata[7:0];
              MCRAM_wr   <= 1'b1;
            end else begin
              state      <= READ;
              MCRAM_addr <= sel_addr;
            end
          end
        end

        READ: begin
          if (!cur_req) begin
            state      <= IDLE;
            MCRAM_addr <= '0;
            MCRAM_wr   <= 1'b0;
            MCRAM_data <= '0;
          end else begin
            rbuf <= rbuf_next;
            if (idx == cur_len) begin
              state      <= FINISH;
              done       <= cur_onehot;
              MCRAM_addr <= '0;
              for (int p = 0; p < N_PORTS; p++) begin
                if (cur_onehot[p]) begin
                  rdata[p*DW +: DW] <= rbuf_next;
                end
              end
            end else begin
              idx        <= idx_inc;
              MCRAM_addr <= (idx_inc < cur_len) ? cur_addr + 32'(idx_inc) : '0;
            end
          end
        end

        WRITE: begin
          if (!cur_req) begin
            state      <= IDLE;
            MCRAM_addr <= '0;
            MCRAM_wr   <= 1'b0;
            MCRAM_data <= '0;
          end else if (idx_inc < cur_len) begin
            idx        <= idx_inc;
            MCRAM_addr <= cur_addr + 32'(idx_inc);
            MCRAM_data <= wd_byte;
          end else begin
            state      <= FINISH;
            done       <= cur_onehot;
            MCRAM_addr <= '0;
            MCRAM_wr   <= 1'b0;
            MCRAM_data <= '0;
          end
        end

        FINISH: begin
          state    <= IDLE;
          done     <= '0;
          blk_vld  <= 1'b1;
          blk_port <= cur_port;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_rr_arb.sv
// tb_mc_rr_arb: directed vector table plus hand-written corner sequences.
module tb_mc_rr_arb;

  localparam int NP = 2;
  localparam int MB = 8;
  localparam int LW = 4;
  localparam int DW = 64;

`ifdef MC_IO_STALL_EN
  localparam bit IO_EFF = 1'b1;
`else
  localparam bit IO_EFF = 1'b0;
`endif

  logic             Sys_clk = 1'b0;
  logic             Sys_rst_n;
  logic             Sys_rdy;
  logic             io_buffer_full;
  logic [7:0]       RAMMC_data;
  logic [7:0]       MCRAM_data;
  logic [31:0]      MCRAM_addr;
  logic             MCRAM_wr;
  logic [NP-1:0]    req_en;
  logic [NP-1:0]    req_wr;
  logic [NP*LW-1:0] req_len;
  logic [NP*32-1:0] req_addr;
  logic [NP*DW-1:0] req_wdata;
  logic [NP-1:0]    done;
  logic [NP*DW-1:0] rdata;

  logic [7:0]  mem [256];
  logic [63:0] exp_rd [NP];
  int          n_tests = 0;
  int          n_fail  = 0;

  typedef struct {
    int          port;
    bit          wr;
    logic [31:0] addr;
    int          len;
    logic [63:0] wdata;
    int          lat;
    logic [63:0] rd;
  } vec_t;

  vec_t tbl [10];

  mc_rr_arb #(.N_PORTS(NP), .MAX_BYTES(MB)) dut (
    .Sys_clk        (Sys_clk),
    .Sys_rst_n      (Sys_rst_n),
    .Sys_rdy        (Sys_rdy),
    .io_buffer_full (io_buffer_full),
    .RAMMC_data     (RAMMC_data),
    .MCRAM_data     (MCRAM_data),
    .MCRAM_addr     (MCRAM_addr),
    .MCRAM_wr       (MCRAM_wr),
    .req_en         (req_en),
    .req_wr         (req_wr),
    .req_len        (req_len),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .done           (done),
    .rdata          (rdata)
  );

  always #5 Sys_clk = ~Sys_clk;

  // Synchronous-read RAM: data appears the cycle after the address.
  always @(posedge Sys_clk) RAMMC_data <= mem[MCRAM_addr[7:0]];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_rdata(input string tag);
    for (int p = 0; p < NP; p++) begin
      chk($sformatf("%s_rdata%0d", tag, p), rdata[p*DW +: DW], exp_rd[p]);
    end
  endtask

  // One transfer with an optional freeze window (kind 1: Sys_rdy, 2: io) and
  // optional abort (requester drops req_en after cycle ab_at).
  task automatic run_xfer(input vec_t v, input int skind, input int s_at,
                          input int s_len, input int ab_at, input string tag);
    int nfroz, p, done_n, budget, len_eff;
    bit bad, eff;
    logic [NP-1:0] e_done;
    logic [31:0]   e_addr;
    logic          e_wr;
    len_eff = (v.len > MB) ? MB : v.len;
    eff     = (skind == 1) || (skind == 2 && IO_EFF);
    budget  = (ab_at > 0) ? v.lat + 4 : v.lat + s_len + 3;
    nfroz   = 0;
    done_n  = -1;
    bad     = 1'b0;
    @(negedge Sys_clk);
    req_wr[v.port]                = v.wr;
    req_len[v.port*LW +: LW]      = LW'(v.len);
    req_addr[v.port*32 +: 32]     = v.addr;
    req_wdata[v.port*DW +: DW]    = v.wdata;
    req_en[v.port]                = 1'b1;
    for (int n = 1; n <= budget; n++) begin
      @(posedge Sys_clk);
      #1;
      if (eff && n > s_at && n <= s_at + s_len) nfroz++;
      p      = n - nfroz;
      e_addr = '0;
      e_wr   = 1'b0;
      e_done = '0;
      if (!(ab_at > 0 && n > ab_at)) begin
        if (p >= 1 && p <= len_eff) begin
          e_addr = v.addr + 32'(p - 1);
          e_wr   = v.wr;
        end
        if (p == v.lat && ab_at == 0) e_done[v.port] = 1'b1;
      end
      if (MCRAM_addr !== e_addr || MCRAM_wr !== e_wr || done !== e_done) bad = 1'b1;
      if (e_wr && MCRAM_data !== 8'(v.wdata >> (8 * (p - 1)))) bad = 1'b1;
      if (done != '0 && done_n < 0) done_n = n;
      if (done[v.port]) req_en[v.port] = 1'b0;
      if (n == ab_at) req_en[v.port] = 1'b0;
      if (skind != 0 && n == s_at) begin
        if (skind == 1) Sys_rdy = 1'b0;
        else io_buffer_full = 1'b1;
      end
      if (skind != 0 && n == s_at + s_len) begin
        Sys_rdy        = 1'b1;
        io_buffer_full = 1'b0;
      end
    end
    req_en[v.port] = 1'b0;
    chk({tag, "_bus"}, 64'(bad), 64'd0);
    if (ab_at > 0) chk({tag, "_no_done"}, 64'(done_n), 64'(-1));
    else chk({tag, "_latency"}, 64'(done_n), 64'(v.lat + (eff ? s_len : 0)));
    if (ab_at == 0 && !v.wr) exp_rd[v.port] = v.rd;
    chk_rdata(tag);
  endtask

  initial begin
    int  d [3];
    int  nd, last, c0, c1;
    bit  acc, alt_bad;
    vec_t rd30, ab_v, st_v;

    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
    for (int p = 0; p < NP; p++) exp_rd[p] = '0;

    tbl[0] = '{0, 1'b0, 32'h0000_1000,  4, 64'h0,                  6, 64'h4433_2211};
    tbl[1] = '{1, 1'b1, 32'h0000_2000,  2, 64'hBEEF,               3, 64'h0};
    tbl[2] = '{1, 1'b0, 32'h0000_3010,  3, 64'h0,                  5, 64'h0012_1110};
    tbl[3] = '{0, 1'b1, 32'h2000_00F0,  8, 64'h8877_6655_4433_2211, 9, 64'h0};
    tbl[4] = '{1, 1'b0, 32'h0000_0050, 12, 64'h0,                 10, 64'h5756_5554_5352_5150};
    tbl[5] = '{1, 1'b0, 32'h0000_0040,  2, 64'h0,                  4, 64'h4140};
    tbl[6] = '{0, 1'b0, 32'hFFFF_FFFE,  4, 64'h0,                  6, 64'h2211_FFFE};
    tbl[7] = '{1, 1'b1, 32'hFFFF_FFFF,  3, 64'hCC_BBAA,            4, 64'h0};
    tbl[8] = '{0, 1'b0, 32'h0000_2000,  0, 64'h0,                  1, 64'h0};
    tbl[9] = '{1, 1'b1, 32'h0000_2000,  0, 64'h1234,               1, 64'h0};
    rd30   = tbl[0];
    ab_v   = '{0, 1'b0, 32'h0000_0050,  8, 64'h0,                 10, 64'h0};
    st_v   = '{1, 1'b1, 32'h0000_2800,  4, 64'h0D0C_0B0A,          5, 64'h0};

    Sys_rst_n = 1'b0; Sys_rdy = 1'b1; io_buffer_full = 1'b0;
    req_en = '0; req_wr = '0; req_len = '0; req_addr = '0; req_wdata = '0;
    #1;
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_addr", 64'(MCRAM_addr), 64'd0);
    chk("reset_wr", 64'(MCRAM_wr), 64'd0);
    chk("reset_data", 64'(MCRAM_data), 64'd0);
    chk_rdata("reset");
    repeat (2) @(posedge Sys_clk);
    @(negedge Sys_clk) Sys_rst_n = 1'b1;
    repeat (2) @(negedge Sys_clk);

    for (int i = 0; i < 10; i++) run_xfer(tbl[i], 0, 0, 0, 0, $sformatf("vec%0d", i));

    // Held zero-length request: done at G+1, then one blocked IDLE cycle.
    @(negedge Sys_clk);
    req_wr[0] = 1'b1; req_len[0 +: LW] = '0; req_addr[0 +: 32] = 32'h3000; req_en[0] = 1'b1;
    nd = 0; acc = 1'b0; d[0] = 0; d[1] = 0; d[2] = 0;
    for (int n = 1; n <= 9; n++) begin
      @(posedge Sys_clk);
      #1;
      if (done[0] && nd < 3) begin d[nd] = n; nd++; end
      if (MCRAM_wr || MCRAM_addr != '0) acc = 1'b1;
    end
    req_en[0] = 1'b0;
    repeat (3) @(posedge Sys_clk);
    chk("len0_first_done", 64'(d[0]), 64'd1);
    chk("len0_regrant_gap", 64'(d[1] - d[0]), 64'd3);
    chk("len0_no_access", 64'(acc), 64'd0);

    // Two ports requesting continuously must alternate.
    @(negedge Sys_clk);
    req_wr = '0;
    req_len = {LW'(1), LW'(1)};
    req_addr = {32'h70, 32'h60};
    req_en = 2'b11;
    last = -1; alt_bad = 1'b0; c0 = 0; c1 = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge Sys_clk);
      #1;
      if (done == 2'b01) begin
        if (last == 0) alt_bad = 1'b1;
        last = 0; c0++;
      end else if (done == 2'b10) begin
        if (last == 1) alt_bad = 1'b1;
        last = 1; c1++;
      end else if (done != 2'b00) alt_bad = 1'b1;
    end
    req_en = '0;
    repeat (4) @(posedge Sys_clk);
    chk("rr_alternate", 64'(alt_bad), 64'd0);
    chk("rr_count0", 64'(c0), 64'd5);
    chk("rr_count1", 64'(c1), 64'd5);
    exp_rd[0] = 64'h60;
    exp_rd[1] = 64'h70;
    chk_rdata("rr");

    // Read abort after three addresses leaves rdata untouched.
    run_xfer(rd30, 0, 0, 0, 0, "pre_abort");
    run_xfer(ab_v, 0, 0, 0, 3, "abort");

    // Freeze windows in the middle of a write.
    run_xfer(st_v, 1, 2, 3, 0, "rdy_stall");
    run_xfer(st_v, 2, 2, 3, 0, "io_stall");

    // Reset in the middle of a write, then a normal transfer.
    @(negedge Sys_clk);
    req_wr[1] = 1'b1; req_len[LW +: LW] = LW'(4); req_addr[32 +: 32] = 32'h2400;
    req_wdata[DW +: DW] = 64'hA1B2_C3D4; req_en[1] = 1'b1;
    @(posedge Sys_clk); #1;
    @(posedge Sys_clk); #1;
    chk("rst_pre_wr", 64'(MCRAM_wr), 64'd1);
    #2 Sys_rst_n = 1'b0;
    #1;
    chk("rst_wr", 64'(MCRAM_wr), 64'd0);
    chk("rst_addr", 64'(MCRAM_addr), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    chk_rdata("rst");
    req_en = '0;
    @(posedge Sys_clk); #1;
    chk("rst_hold_done", 64'(done), 64'd0);
    @(negedge Sys_clk) Sys_rst_n = 1'b1;
    run_xfer(rd30, 0, 0, 0, 0, "post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
